traffic_phase_ctrl: RTL
=======================

// Module: traffic_phase_ctrl
// PURPOSE
//  Parametrised multi-signal traffic-light phase sequencer. It replaces the fixed 3-signal/5-state controller.
//  Cycles N_PHASE phases, each with a per-phase green mask, timed in seconds from a writable
//  N_TABLE x N_PHASE timing table. Inserts a yellow interval for signals leaving green.
//  Vehicle sensors select the timing table and a priority-phase jump; push buttons shorten green.
//  Drives the lamp drivers and emits per-signal change pulses.
// PARAMETERS
//  TICK_DIV    48_000_000        CLK cycles per 1 s tick (48 MHz); benches use a small value
//  N_SIG       3                 signals; idx 0=NN, 1=NS, 2=TH
//  N_PHASE     5                 phases, max 8
//  N_TABLE     4                 timing tables, max 4 (A..D)
//  TW          8                 timer width in seconds
//  YEL_S       3                 yellow duration in s (>=1)
//  PB_CUT      5                 remaining green after a button request, in s
//  PHASE_GREEN {001,010,100,000,011}  green mask per phase, P4..P0; bit i = signal i
//  PRIO_PHASE  {2,3,4}           priority phase per sensor, S2..S0
//  SENS_TABLE  {1,3,2}           table per sensor, S2..S0
// PORTS
//  CLK       in   1             system clock
//  RESET     in   1             synchronous, active-high
//  SENS      in   N_SIG         vehicle sensors, level, already synchronised
//  PB        in   N_SIG         pedestrian buttons, already synchronised
//  CFG_WE    in   1             timing-table write strobe
//  CFG_TAB   in   2             table index
//  CFG_PH    in   3             phase index
//  CFG_DATA  in   TW            phase time in s
//  LG/LY/LR  out  N_SIG each    green/yellow/red lamp, exactly one-hot per signal
//  CS        out  N_SIG         1-cycle pulse when the signal's lamp changes
//  PHASE     out  3             current phase
//  TABLE     out  2             active table
// BEHAVIOUR
//  Reset (RESET=1 at posedge CLK):
//   - PHASE=0, TABLE=0, FSM=RUN, prescaler=0, button requests cleared, CS=0
//   - lamps per PHASE_GREEN[0]: green where the bit is 1, else red; no yellow
//   - timer=T[0][0]
//   - table restored; rows = phases P0..P4:
//     A={17,3,55,27,24}, B={3,3,110,14,12}, C={17,3,27,14,48}, D={17,3,27,54,12}
//   - Reset mid-operation aborts the sequence at once; same values apply.
//  Tick:
//   - prescaler counts 0..TICK_DIV-1; tick=1 for one cycle at TICK_DIV-1
//   - timer decrements on tick only
//  FSM states: RUN, YEL.
//  RUN:
//   - On tick with timer==1, the phase ends; compute next phase NP and table NT.
//   - If exactly one SENS[i]=1 that cycle, and PRIO_PHASE[i] != PHASE:
//     NP=PRIO_PHASE[i], NT=SENS_TABLE[i].
//   - Otherwise NP=(PHASE+1) mod N_PHASE; NT=0 if no sensor active.
//     With two or more sensors active, or a single sensor whose priority phase is current, NT=TABLE.
//   - leave = PHASE_GREEN[PHASE] & ~PHASE_GREEN[NP].
//   - If leave!=0: go to YEL; leave signals show yellow; timer=YEL_S; NP/NT held.
//   - Else: PHASE=NP, TABLE=NT, timer=T[NT][NP], lamps applied; all in the same cycle.
//  YEL:
//   - On tick with timer==1: PHASE=NP, TABLE=NT, timer=T[NT][NP].
//   - Lamps per the new mask.
//   - Sensors are not re-evaluated during YEL.
//  Timing:
//   - Lamp outputs are registered and change in the cycle after the deciding tick.
//   - CS[i]=1 in that same cycle, for every signal whose lamp changed.
//   - A loaded time of 0 is treated as 1.
//  Buttons:
//   - A rising edge of PB[i] sets req[i].
//   - In RUN: if req[i]=1, signal i is green, and timer>PB_CUT, then timer=PB_CUT on the next cycle. Does not stretch green.
//   - req[i] clears when signal i goes yellow/red.
//   - A press in the same cycle as the clear stays set.
//  Config:
//   - While CFG_WE=1, T[CFG_TAB][CFG_PH]=CFG_DATA.
//   - Ignored if CFG_PH>=N_PHASE or CFG_TAB>=N_TABLE.
//   - A write never alters the running timer.
//   - A write in the same cycle as a load of the same entry: the load uses the old value, and the new value applies next time.
//  Invariants: yellow only in YEL; never green and yellow on one signal; PHASE<N_PHASE.
// TESTING
//  1 TICK_DIV=4, no inputs:
//    P0 holds 17 ticks; P0->P1 leaves 011 -> NN,NS yellow 3 ticks, CS=011, then P1 all red 3 ticks.
//  2 SENS=100 (TH) held at the end of P0:
//    yellow 3 ticks -> PHASE=2, TABLE=1, TH green 110 ticks.
//  3 SENS=011 (two sensors):
//    no jump; PHASE increments; TABLE unchanged.
//  4 Button with NN green in P0, timer=12, PB[0] pulse:
//    timer=5 next cycle; req[0] clears when NN goes yellow.
//  5 CFG write T[0][0]=9 during P0:
//    current P0 is unaffected; the next P0 lasts 9 ticks.
//    Write with CFG_PH=6: ignored.
//  6 RESET asserted mid-YEL:
//    next cycle PHASE=0, LG=011, LY=000, timer=17, table back to defaults.

Source files
------------

// File: rtl/traffic_phase_ctrl.sv
// traffic_phase_ctrl: parametrised multi-signal traffic-light phase sequencer.
// Steps through N_PHASE green masks timed from a writable timing table. It
// inserts a yellow interval for signals that leave green. Vehicle sensors can
// force a priority phase and select a timing table. Pedestrian buttons shorten
// a running green. Lamp outputs are registered. CS pulses for one cycle on
// every lamp change.
module traffic_phase_ctrl #(
  parameter int TICK_DIV = 48_000_000,
  parameter int N_SIG    = 3,
  parameter int N_PHASE  = 5,
  parameter int N_TABLE  = 4,
  parameter int TW       = 8,
  parameter int YEL_S    = 3,
  parameter int PB_CUT   = 5,
  // green mask per phase, P(N_PHASE-1)..P0; bit i = signal i
  parameter logic [N_PHASE*N_SIG-1:0] PHASE_GREEN = {3'b001, 3'b010, 3'b100, 3'b000, 3'b011},
  // priority phase and timing table per sensor, S(N_SIG-1)..S0
  parameter logic [N_SIG*3-1:0]       PRIO_PHASE  = {3'd2, 3'd3, 3'd4},
  parameter logic [N_SIG*2-1:0]       SENS_TABLE  = {2'd1, 2'd3, 2'd2},
  // default timing table; entry [t][p] sits at bit offset (t*N_PHASE+p)*TW
  parameter logic [N_TABLE*N_PHASE*TW-1:0] T_INIT = {
    8'd12, 8'd54, 8'd27,  8'd3, 8'd17,   // D: P4..P0
    8'd48, 8'd14, 8'd27,  8'd3, 8'd17,   // C
    8'd12, 8'd14, 8'd110, 8'd3, 8'd3,    // B
    8'd24, 8'd27, 8'd55,  8'd3, 8'd17    // A
  }
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [N_SIG-1:0] SENS,
  input  logic [N_SIG-1:0] PB,
  input  logic             CFG_WE,
  input  logic [1:0]       CFG_TAB,
  input  logic [2:0]       CFG_PH,
  input  logic [TW-1:0]    CFG_DATA,
  output logic [N_SIG-1:0] LG,
  output logic [N_SIG-1:0] LY,
  output logic [N_SIG-1:0] LR,
  output logic [N_SIG-1:0] CS,
  output logic [2:0]       PHASE,
  output logic [1:0]       TABLE
);

  typedef enum logic {RUN, YEL} state_t;

  localparam int            PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] PB_CUT_T = TW'(PB_CUT);
  localparam logic [TW-1:0] YEL_T    = TW'(YEL_S);

  function automatic logic [N_SIG-1:0] green_of(input logic [2:0] p);
    return PHASE_GREEN[int'(p)*N_SIG +: N_SIG];
  endfunction

  // A stored time of zero would underflow the down-counter, so it runs as 1 s.
  function automatic logic [TW-1:0] nz(input logic [TW-1:0] t);
    return (t == '0) ? TW'(1) : t;
  endfunction

  logic [PW-1:0]    presc_q;
  logic             tick;
  logic [TW-1:0]    tbl [N_TABLE][N_PHASE];

  state_t           state_q, state_d;
  logic [2:0]       phase_q, phase_d, np_q, np_d, np_c;
  logic [1:0]       table_q, table_d, nt_q, nt_d, nt_c;
  logic [TW-1:0]    timer_q, timer_d;
  logic [N_SIG-1:0] lg_q, lg_d, ly_q, ly_d, lr_q, lr_d, cs_q, cs_d;
  logic [N_SIG-1:0] req_q, req_d, pb_q, pb_rise, leave;
  logic             cut;

  assign tick    = (presc_q == PW'(TICK_DIV - 1));
  assign pb_rise = PB & ~pb_q;

  assign LG    = lg_q;
  assign LY    = ly_q;
  assign LR    = lr_q;
  assign CS    = cs_q;
  assign PHASE = phase_q;
  assign TABLE = table_q;

  // Free-running prescaler producing a one-cycle tick every TICK_DIV cycles.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values regardless of statement order.
    if (RESET) presc_q <= '0;
    else       presc_q <= tick ? '0 : presc_q + PW'(1);
  end

  // Timing table: restored on reset, written by the config port when in range.
  always_ff @(posedge CLK) begin
    // NOTE: this memory is reset on purpose because reset must restore the
    // default timings; plain data RAMs normally carry no reset.
    if (RESET) begin
      for (int t = 0; t < N_TABLE; t++)
        for (int p = 0; p < N_PHASE; p++)
          tbl[t][p] <= T_INIT[(t*N_PHASE + p)*TW +: TW];
    end else if (CFG_WE && int'(CFG_TAB) < N_TABLE && int'(CFG_PH) < N_PHASE) begin
      tbl[CFG_TAB][CFG_PH] <= CFG_DATA;
    end
  end

  // Next phase/table if the running phase ended now, and who leaves green.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch; blocking (=) is correct here.
    np_c = (phase_q == 3'(N_PHASE - 1)) ? 3'd0 : phase_q + 3'd1;
    nt_c = table_q;
    if (SENS == '0) begin
      nt_c = 2'd0;
    end else if ($onehot(SENS)) begin
      for (int i = 0; i < N_SIG; i++) begin
        if (SENS[i] && PRIO_PHASE[i*3 +: 3] != phase_q) begin
          np_c = PRIO_PHASE[i*3 +: 3];
          nt_c = SENS_TABLE[i*2 +: 2];
        end
      end
    end
    leave = green_of(phase_q) & ~green_of(np_c);
  end

  // FSM next state, timer, lamps, button requests and change pulses.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    table_d = table_q;
    timer_d = timer_q;
    np_d    = np_q;
    nt_d    = nt_q;
    lg_d    = lg_q;
    ly_d    = ly_q;
    lr_d    = lr_q;
    cut     = (|((req_q | pb_rise) & lg_q)) && (timer_q > PB_CUT_T);

    case (state_q)
      RUN: begin
        if (tick && timer_q == TW'(1)) begin
          if (leave != '0) begin
            state_d = YEL;
            timer_d = YEL_T;
            np_d    = np_c;
            nt_d    = nt_c;
            lg_d    = green_of(phase_q) & ~leave;
            ly_d    = leave;
            lr_d    = ~green_of(phase_q);
          end else begin
            phase_d = np_c;
            table_d = nt_c;
            timer_d = nz(tbl[nt_c][np_c]);
            lg_d    = green_of(np_c);
            ly_d    = '0;
            lr_d    = ~green_of(np_c);
          end
        end else if (cut) begin
          timer_d = PB_CUT_T;
        end else if (tick) begin
          timer_d = timer_q - TW'(1);
        end
      end
      YEL: begin
        if (tick && timer_q == TW'(1)) begin
          state_d = RUN;
          phase_d = np_q;
          table_d = nt_q;
          timer_d = nz(tbl[nt_q][np_q]);
          lg_d    = green_of(np_q);
          ly_d    = '0;
          lr_d    = ~green_of(np_q);
        end else if (tick) begin
          timer_d = timer_q - TW'(1);
        end
      end
    endcase

    // A request is served once its signal stops being green; a new press wins.
    req_d = (req_q & ~(lg_q & ~lg_d)) | pb_rise;
    cs_d  = (lg_q ^ lg_d) | (ly_q ^ ly_d) | (lr_q ^ lr_d);
  end

  // Controller state register.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= RUN;
      phase_q <= '0;
      table_q <= '0;
      np_q    <= '0;
      nt_q    <= '0;
      timer_q <= nz(T_INIT[TW-1:0]);
      lg_q    <= green_of(3'd0);
      ly_q    <= '0;
      lr_q    <= ~green_of(3'd0);
      cs_q    <= '0;
      req_q   <= '0;
      pb_q    <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      table_q <= table_d;
      np_q    <= np_d;
      nt_q    <= nt_d;
      timer_q <= timer_d;
      lg_q    <= lg_d;
      ly_q    <= ly_d;
      lr_q    <= lr_d;
      cs_q    <= cs_d;
      req_q   <= req_d;
      pb_q    <= PB;
    end
  end

endmodule
